// File: rtl/aes_host_sequencer_pkg.sv
// Shared definitions for the AES host sequencer: command codes, mode encodings,
// FSM states and the buffered command entry layout.
package aes_seq_pkg;

    typedef enum logic [1:0] {
        CMD_KEY  = 2'b00,
        CMD_IV   = 2'b01,
        CMD_DATA = 2'b10,
        CMD_GO   = 2'b11
    } cmd_type_e;

    localparam logic [1:0] OP_ENC         = 2'b00;
    localparam logic [1:0] OP_KEY_DERIV   = 2'b01;
    localparam logic [1:0] OP_DEC         = 2'b10;
    localparam logic [1:0] OP_DEC_W_DERIV = 2'b11;

    localparam logic [1:0] MODE_ECB = 2'b00;
    localparam logic [1:0] MODE_CBC = 2'b01;
    localparam logic [1:0] MODE_CTR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        cmd_type_e   ctype;
        logic [31:0] word;
    } cmd_entry_t;

    // Word 0 of a group lands on strobe bit 0, matching aes_core's word order.
    function automatic logic [3:0] word_strobe(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/aes_host_sequencer_if.sv
// Host command channel: tagged 32-bit words over a valid/ready handshake.
interface aes_host_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [31:0] cmd_word;

    modport master (output cmd_valid, output cmd_type, output cmd_word, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_type, input cmd_word, output cmd_ready);
endinterface

// File: rtl/aes_host_sequencer_fifo.sv
// aes_word_fifo: small first-word-fall-through buffer for {type,word} command entries.
module aes_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        data_o  = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/aes_host_sequencer.sv
// Front-end for aes_core: turns buffered KEY/IV/DATA/GO words into core strobes and start.
// Optional BUSY watchdog enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_host_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_host_sequencer_if.slave  cmd,
    input  logic [1:0]           cfg_op_mode,
    input  logic [1:0]           cfg_aes_mode,
    input  logic                 cfg_first,
    input  logic                 core_done,
    output logic [31:0]          bus_in,
    output logic [3:0]           key_en,
    output logic [3:0]           iv_en,
    output logic [1:0]           addr,
    output logic                 write_en,
    output logic [1:0]           data_type,
    output logic [1:0]           op_mode,
    output logic [1:0]           aes_mode,
    output logic                 first_block,
    output logic                 start,
    output logic                 busy,
    output logic                 blk_done,
    output logic                 err
);
    localparam int unsigned ENTRY_W = $bits(cmd_entry_t);

    seq_state_e       state_q;
    cmd_type_e        last_type_q;
    logic [1:0]       cnt_q;
    logic [31:0]      bus_in_q;
    logic [3:0]       key_en_q;
    logic [3:0]       iv_en_q;
    logic [1:0]       addr_q;
    logic             write_en_q;
    logic [1:0]       op_mode_q;
    logic [1:0]       aes_mode_q;
    logic             first_block_q;
    logic             start_q;
    logic             busy_q;
    logic             blk_done_q;
    logic             err_q;

    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    cmd_entry_t         head;
    logic               type_err;
    logic [1:0]         idx_d;
    logic [1:0]         cnt_d;

    assign cmd.cmd_ready = !fifo_full && (state_q != ST_BUSY);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

    aes_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({cmd.cmd_type, cmd.cmd_word}),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A word of a new type arriving mid-group flags an error and restarts the index.
    always_comb begin
        head     = cmd_entry_t'(fifo_rdata);
        pop      = (state_q == ST_IDLE) && !fifo_empty;
        type_err = pop && (head.ctype != CMD_GO) && (cnt_q != 2'd0) && (head.ctype != last_type_q);
        idx_d    = type_err ? 2'd0 : cnt_q;
        cnt_d    = idx_d + 2'd1;
    end

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_q;
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_type_q   <= CMD_KEY;
            cnt_q         <= '0;
            bus_in_q      <= '0;
            key_en_q      <= '0;
            iv_en_q       <= '0;
            addr_q        <= '0;
            write_en_q    <= 1'b0;
            op_mode_q     <= '0;
            aes_mode_q    <= '0;
            first_block_q <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            blk_done_q    <= 1'b0;
            err_q         <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            key_en_q   <= '0;
            iv_en_q    <= '0;
            write_en_q <= 1'b0;
            start_q    <= 1'b0;
            blk_done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        if (head.ctype == CMD_GO) begin
                            if (cnt_q != 2'd0) begin
                                err_q <= 1'b1;
                            end else begin
                                op_mode_q     <= cfg_op_mode;
                                aes_mode_q    <= cfg_aes_mode;
                                first_block_q <= cfg_first;
                                start_q       <= 1'b1;
                                busy_q        <= 1'b1;
                                state_q       <= ST_START;
                            end
                        end else begin
                            if (type_err) err_q <= 1'b1;
                            bus_in_q    <= head.word;
                            last_type_q <= head.ctype;
                            cnt_q       <= cnt_d;
                            case (head.ctype)
                                CMD_KEY: key_en_q <= word_strobe(idx_d);
                                CMD_IV:  iv_en_q  <= word_strobe(idx_d);
                                default: begin
                                    addr_q     <= idx_d;
                                    write_en_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_START: state_q <= ST_BUSY;
                ST_BUSY: begin
`ifdef AES_SEQ_TIMEOUT_EN
                    if (core_done) begin
                        blk_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        tmo_q      <= '0;
                        state_q    <= ST_DONE;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        err_q      <= 1'b1;
                        blk_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        tmo_q      <= '0;
                        state_q    <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`else
                    if (core_done) begin
                        blk_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_DONE;
                    end
`endif
                end
                ST_DONE: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_in      = bus_in_q;
    assign key_en      = key_en_q;
    assign iv_en       = iv_en_q;
    assign addr        = addr_q;
    assign write_en    = write_en_q;
    assign data_type   = 2'b00;
    assign op_mode     = op_mode_q;
    assign aes_mode    = aes_mode_q;
    assign first_block = first_block_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign blk_done    = blk_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_aes_host_sequencer.sv
// Directed bench for aes_host_sequencer: word strobes, start/done timing, errors, hold, reset.
module tb_aes_host_sequencer;
    import aes_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_op_mode;
    logic [1:0]  cfg_aes_mode;
    logic        cfg_first;
    logic        core_done;
    logic [31:0] bus_in;
    logic [3:0]  key_en;
    logic [3:0]  iv_en;
    logic [1:0]  addr;
    logic        write_en;
    logic [1:0]  data_type;
    logic [1:0]  op_mode;
    logic [1:0]  aes_mode;
    logic        first_block;
    logic        start;
    logic        busy;
    logic        blk_done;
    logic        err;

    aes_host_sequencer_if hif ();

    aes_host_sequencer #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (hif),
        .cfg_op_mode  (cfg_op_mode),
        .cfg_aes_mode (cfg_aes_mode),
        .cfg_first    (cfg_first),
        .core_done    (core_done),
        .bus_in       (bus_in),
        .key_en       (key_en),
        .iv_en        (iv_en),
        .addr         (addr),
        .write_en     (write_en),
        .data_type    (data_type),
        .op_mode      (op_mode),
        .aes_mode     (aes_mode),
        .first_block  (first_block),
        .start        (start),
        .busy         (busy),
        .blk_done     (blk_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_start = 0;
    int n_done = 0;
    int last_acc = 0;
    int s_cyc = 0;
    logic [63:0] slog[$];
    int          scyc[$];

    logic [21:0] ctl_vec;
    assign ctl_vec = {busy, start, blk_done, err, key_en, iv_en, write_en, addr,
                      data_type, op_mode, aes_mode, first_block};

    logic [3:0]  STRB [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] KEYW [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    logic [31:0] DATW [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    logic [31:0] D2W  [4] = '{32'hdeadbeef, 32'hcafef00d, 32'h01234567, 32'h89abcdef};
    logic [31:0] IVW  [4] = '{32'hf0f1f2f3, 32'hf4f5f6f7, 32'hf8f9fafb, 32'hfcfdfeff};
    logic [31:0] EW   [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (key_en != 4'b0 || iv_en != 4'b0 || write_en) begin
            slog.push_back({key_en, iv_en, write_en, (write_en ? addr : 2'b00), 21'b0, bus_in});
            scyc.push_back(cyc);
        end
        if (start)    n_start++;
        if (blk_done) n_done++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind 0 KEY, 1 IV, 2 DATA
    function automatic logic [63:0] ev(input int kind, input int idx, input logic [31:0] w);
        logic [3:0] k;
        logic [3:0] v;
        logic       we;
        logic [1:0] a;
        k = 4'b0; v = 4'b0; we = 1'b0; a = 2'b0;
        case (kind)
            0: k = STRB[idx];
            1: v = STRB[idx];
            default: begin we = 1'b1; a = 2'(idx); end
        endcase
        return {k, v, we, a, 21'b0, w};
    endfunction

    task automatic push(input logic [1:0] t, input logic [31:0] w);
        int n;
        n = 0;
        hif.cmd_valid = 1'b1;
        hif.cmd_type  = t;
        hif.cmd_word  = w;
        while (!hif.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!hif.cmd_ready) begin
            check_eq("push_ready_timeout", {63'b0, hif.cmd_ready}, 64'd1);
        end else begin
            @(negedge clk);
            last_acc = cyc;
        end
        hif.cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("start_seen", {63'b0, start}, 64'd1);
        s_cyc = cyc;
    endtask

    task automatic pulse_done(input int delay);
        repeat (delay) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    task automatic check_log(input string tag, input int n, input logic [63:0] exp [8]);
        check_eq({tag, "_count"}, 64'(slog.size()), 64'(n));
        for (int i = 0; i < n && i < slog.size(); i++)
            check_eq($sformatf("%s_%0d", tag, i), slog[i], exp[i]);
        slog.delete();
        scyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp [8];
        int ns0;
        int nd0;

        rst = 1'b1;
        core_done = 1'b0;
        cfg_op_mode = OP_ENC;
        cfg_aes_mode = MODE_ECB;
        cfg_first = 1'b1;
        hif.cmd_valid = 1'b0;
        hif.cmd_type = CMD_KEY;
        hif.cmd_word = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctl", 64'(ctl_vec), 64'd0);
        check_eq("reset_bus_in", 64'(bus_in), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", {63'b0, hif.cmd_ready}, 64'd1);

        // ECB encryption block
        for (int i = 0; i < 4; i++) push(CMD_KEY, KEYW[i]);
        for (int i = 0; i < 4; i++) push(CMD_DATA, DATW[i]);
        push(CMD_GO, 32'h0);
        wait_start();
        check_eq("start_latency", 64'(s_cyc - last_acc), 64'd1);
        check_eq("busy_on_start", {63'b0, busy}, 64'd1);
        check_eq("cfg_latched", {58'b0, op_mode, aes_mode, first_block}, {58'b0, OP_ENC, MODE_ECB, 1'b1});
        for (int i = 0; i < 4; i++) exp[i] = ev(0, i, KEYW[i]);
        for (int i = 0; i < 4; i++) exp[4+i] = ev(2, i, DATW[i]);
        check_log("ecb_strobe", 8, exp);
        @(negedge clk);
        check_eq("start_width", {63'b0, start}, 64'd0);
        pulse_done(19);
        check_eq("blk_done_next", {63'b0, blk_done}, 64'd1);
        check_eq("busy_low_done", {63'b0, busy}, 64'd0);
        check_eq("ready_after_done", {63'b0, hif.cmd_ready}, 64'd1);
        @(negedge clk);
        check_eq("blk_done_width", {63'b0, blk_done}, 64'd0);
        check_eq("start_count1", 64'(n_start), 64'd1);

        // Config hold during BUSY plus back-pressure
        cfg_op_mode = OP_ENC;
        cfg_aes_mode = MODE_CBC;
        cfg_first = 1'b0;
        for (int i = 0; i < 4; i++) push(CMD_DATA, D2W[i]);
        push(CMD_GO, 32'h0);
        wait_start();
        for (int i = 0; i < 4; i++) exp[i] = ev(2, i, D2W[i]);
        check_log("cbc_data", 4, exp);
        @(negedge clk);
        cfg_op_mode = OP_DEC;
        repeat (3) @(negedge clk);
        check_eq("cfg_hold", {58'b0, op_mode, aes_mode, first_block}, {58'b0, OP_ENC, MODE_CBC, 1'b0});
        hif.cmd_valid = 1'b1;
        hif.cmd_type = CMD_IV;
        hif.cmd_word = IVW[0];
        repeat (3) @(negedge clk);
        check_eq("busy_backpressure", {63'b0, hif.cmd_ready}, 64'd0);
        check_eq("busy_no_strobe", 64'(slog.size()), 64'd0);
        fork
            begin
                for (int i = 0; i < 4; i++) push(CMD_IV, IVW[i]);
                push(CMD_DATA, EW[0]);
                push(CMD_DATA, EW[1]);
            end
            pulse_done(5);
        join
        check_eq("op_mode_until_go", 64'(op_mode), 64'(OP_ENC));
        push(CMD_DATA, EW[2]);
        push(CMD_DATA, EW[3]);
        push(CMD_GO, 32'h0);
        wait_start();
        check_eq("op_mode_new_go", 64'(op_mode), 64'(OP_DEC));
        for (int i = 0; i < 4; i++) exp[i] = ev(1, i, IVW[i]);
        for (int i = 0; i < 4; i++) exp[4+i] = ev(2, i, EW[i]);
        check_log("bp_no_loss", 8, exp);
        pulse_done(4);
        @(negedge clk);
        check_eq("done_count", 64'(n_done), 64'd2 + 64'd1);

        // core_done while IDLE has no effect
        nd0 = n_done;
        pulse_done(2);
        @(negedge clk);
        check_eq("idle_core_done", 64'(n_done - nd0), 64'd0);
        check_eq("err_before_partial", {63'b0, err}, 64'd0);

        // Partial group then GO
        ns0 = n_start;
        push(CMD_DATA, DATW[0]);
        push(CMD_DATA, DATW[1]);
        push(CMD_GO, 32'h0);
        repeat (5) @(negedge clk);
        check_eq("partial_err", {63'b0, err}, 64'd1);
        check_eq("partial_no_start", 64'(n_start - ns0), 64'd0);
        check_eq("partial_idle", {62'b0, busy, hif.cmd_ready}, 64'd1);
        exp[0] = ev(2, 0, DATW[0]);
        exp[1] = ev(2, 1, DATW[1]);
        check_log("partial_data", 2, exp);

        // Reset in the middle of a block
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("err_cleared", {63'b0, err}, 64'd0);
        cfg_op_mode = OP_DEC_W_DERIV;
        cfg_aes_mode = MODE_CTR;
        cfg_first = 1'b1;
        for (int i = 0; i < 4; i++) push(CMD_KEY, KEYW[i]);
        push(CMD_GO, 32'h0);
        wait_start();
        repeat (3) @(negedge clk);
        check_eq("pre_rst_busy", {63'b0, busy}, 64'd1);
        ns0 = n_start;
        rst = 1'b1;
        #1;
        check_eq("rst_async_ctl", 64'(ctl_vec), 64'd0);
        check_eq("rst_async_bus", 64'(bus_in), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("rst_no_restart", 64'(n_start - ns0), 64'd0);
        check_eq("rst_stay_idle", {62'b0, busy, hif.cmd_ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
